// File: rtl/trap_ctrl_pkg.sv
// Shared constants for the machine-mode trap sequencer: CSR addresses, mstatus fields, kinds, causes, FSM states.
// ST_W_TVAL exists only when TRAP_MTVAL_EN is defined.
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_LO   = 11;
  localparam int MPP_HI   = 12;

  localparam int CAUSE_ECALL_DEF   = 11;
  localparam int CAUSE_EBREAK_DEF  = 3;
  localparam int CAUSE_ILLEGAL_DEF = 2;

  typedef enum logic [1:0] {
    KIND_ECALL   = 2'b00,
    KIND_EBREAK  = 2'b01,
    KIND_ILLEGAL = 2'b10,
    KIND_MRET    = 2'b11
  } trap_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_EPC,
    ST_W_CAUSE,
    ST_W_STATUS,
`ifdef TRAP_MTVAL_EN
    ST_W_TVAL,
`endif
    ST_REDIRECT,
    ST_M_STATUS,
    ST_M_REDIRECT
  } state_e;

endpackage

// File: rtl/trap_ctrl_if.sv
// Bundle between decode/core/CSR file (master) and trap_ctrl (slave).
// trap_tval is present only when TRAP_MTVAL_EN is defined.
interface trap_ctrl_if #(parameter int XLEN = 32);

  logic            trap_valid;
  logic            trap_ready;
  logic [1:0]      trap_kind;
  logic [XLEN-1:0] trap_pc;
`ifdef TRAP_MTVAL_EN
  logic [XLEN-1:0] trap_tval;
`endif
  logic [11:0]     core_csr_addr;
  logic [XLEN-1:0] core_csr_wdata;
  logic            core_csr_wen;
  logic            core_csr_gnt;
  logic [XLEN-1:0] core_csr_rdata;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic            csr_wen;
  logic [XLEN-1:0] csr_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            busy;

  modport slave (
    input  trap_valid, trap_kind, trap_pc,
`ifdef TRAP_MTVAL_EN
    trap_tval,
`endif
    core_csr_addr, core_csr_wdata, core_csr_wen, csr_rdata,
    output trap_ready, core_csr_gnt, core_csr_rdata, csr_addr, csr_wdata, csr_wen,
    redirect_valid, redirect_pc, busy
  );

  modport master (
    output trap_valid, trap_kind, trap_pc,
`ifdef TRAP_MTVAL_EN
    trap_tval,
`endif
    core_csr_addr, core_csr_wdata, core_csr_wen, csr_rdata,
    input  trap_ready, core_csr_gnt, core_csr_rdata, csr_addr, csr_wdata, csr_wen,
    redirect_valid, redirect_pc, busy
  );

endinterface

// File: rtl/trap_ctrl.sv
// Trap/mret sequencer owning the CSR port: exception redirect 4 cycles after accept (5 with TRAP_MTVAL_EN), mret 2.
// Backpressure: trap_ready only in IDLE; the core gets the port only in IDLE with no trap pending and must hold.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int CAUSE_ECALL   = CAUSE_ECALL_DEF,
  parameter int CAUSE_EBREAK  = CAUSE_EBREAK_DEF,
  parameter int CAUSE_ILLEGAL = CAUSE_ILLEGAL_DEF
) (
  input logic        clk,
  input logic        rst_n,
  trap_ctrl_if.slave bus
);

  state_e          state;
  logic [XLEN-1:0] pc_q;
  trap_kind_e      kind_q;
`ifdef TRAP_MTVAL_EN
  logic [XLEN-1:0] tval_q;
`endif

  logic            idle;
  logic            accept;
  logic [11:0]     addr;
  logic [XLEN-1:0] wdata;
  logic            wen;
  logic            redir;
  logic [XLEN-1:0] status_upd;

  function automatic logic [XLEN-1:0] cause_of(trap_kind_e k);
    case (k)
      KIND_EBREAK:  return XLEN'(CAUSE_EBREAK);
      KIND_ILLEGAL: return XLEN'(CAUSE_ILLEGAL);
      default:      return XLEN'(CAUSE_ECALL);
    endcase
  endfunction

  assign idle   = (state == ST_IDLE);
  assign accept = idle && bus.trap_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      pc_q   <= '0;
      kind_q <= KIND_ECALL;
`ifdef TRAP_MTVAL_EN
      tval_q <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            pc_q   <= bus.trap_pc & ~XLEN'(3);
            kind_q <= trap_kind_e'(bus.trap_kind);
`ifdef TRAP_MTVAL_EN
            tval_q <= bus.trap_tval;
`endif
            state  <= (trap_kind_e'(bus.trap_kind) == KIND_MRET) ? ST_M_STATUS : ST_W_EPC;
          end
        end
        ST_W_EPC:    state <= ST_W_CAUSE;
        ST_W_CAUSE:  state <= ST_W_STATUS;
`ifdef TRAP_MTVAL_EN
        ST_W_STATUS: state <= ST_W_TVAL;
        ST_W_TVAL:   state <= ST_REDIRECT;
`else
        ST_W_STATUS: state <= ST_REDIRECT;
`endif
        ST_M_STATUS: state <= ST_M_REDIRECT;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  // In IDLE the port mirrors the core; every sequence state overrides it.
  always_comb begin
    addr       = bus.core_csr_addr;
    wdata      = bus.core_csr_wdata;
    wen        = bus.core_csr_wen && idle && !bus.trap_valid;
    redir      = 1'b0;
    status_upd = bus.csr_rdata;
    case (state)
      ST_W_EPC: begin
        addr  = CSR_MEPC;
        wdata = pc_q;
        wen   = 1'b1;
      end
      ST_W_CAUSE: begin
        addr  = CSR_MCAUSE;
        wdata = cause_of(kind_q);
        wen   = 1'b1;
      end
      ST_W_STATUS: begin
        status_upd[MPIE_BIT]      = bus.csr_rdata[MIE_BIT];
        status_upd[MIE_BIT]       = 1'b0;
        status_upd[MPP_HI:MPP_LO] = 2'b11;
        addr  = CSR_MSTATUS;
        wdata = status_upd;
        wen   = 1'b1;
      end
`ifdef TRAP_MTVAL_EN
      ST_W_TVAL: begin
        addr  = CSR_MTVAL;
        wdata = (kind_q == KIND_ILLEGAL) ? tval_q : '0;
        wen   = 1'b1;
      end
`endif
      ST_REDIRECT: begin
        addr  = CSR_MTVEC;
        wdata = '0;
        wen   = 1'b0;
        redir = 1'b1;
      end
      ST_M_STATUS: begin
        status_upd[MIE_BIT]       = bus.csr_rdata[MPIE_BIT];
        status_upd[MPIE_BIT]      = 1'b1;
        status_upd[MPP_HI:MPP_LO] = 2'b11;
        addr  = CSR_MSTATUS;
        wdata = status_upd;
        wen   = 1'b1;
      end
      ST_M_REDIRECT: begin
        addr  = CSR_MEPC;
        wdata = '0;
        wen   = 1'b0;
        redir = 1'b1;
      end
      default: ;
    endcase
  end

  // Gating with rst_n keeps a reset cycle from committing a half-finished sequence step.
  assign bus.csr_addr       = addr;
  assign bus.csr_wdata      = wdata;
  assign bus.csr_wen        = wen && rst_n;
  assign bus.redirect_valid = redir && rst_n;
  assign bus.redirect_pc    = {bus.csr_rdata[XLEN-1:2], 2'b00};
  assign bus.trap_ready     = idle;
  assign bus.core_csr_gnt   = idle && !bus.trap_valid;
  assign bus.core_csr_rdata = bus.csr_rdata;
  assign bus.busy           = !idle;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: a small CSR-file model answers the port; trap outcomes are checked against spec-level rules.
`timescale 1ns/1ps
module tb_trap_ctrl;

  localparam int XLEN = 32;
`ifdef TRAP_MTVAL_EN
  localparam int EXC_LAT = 5;
`else
  localparam int EXC_LAT = 4;
`endif
  localparam logic [1:0] K_ECALL = 2'd0, K_EBREAK = 2'd1, K_ILLEGAL = 2'd2, K_MRET = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [31:0] last_tval = '0;
  logic [31:0] m_status = '0, m_tvec = '0, m_epc = '0, m_cause = '0, m_tval = '0;

  always #5 clk = ~clk;

  trap_ctrl_if #(.XLEN(XLEN)) bus ();
  trap_ctrl #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always_comb begin
    case (bus.csr_addr)
      12'h300: bus.csr_rdata = m_status;
      12'h305: bus.csr_rdata = m_tvec;
      12'h341: bus.csr_rdata = m_epc;
      12'h342: bus.csr_rdata = m_cause;
      12'h343: bus.csr_rdata = m_tval;
      default: bus.csr_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    if (bus.csr_wen === 1'b1) begin
      case (bus.csr_addr)
        12'h300: m_status <= bus.csr_wdata;
        12'h305: m_tvec   <= bus.csr_wdata;
        12'h341: m_epc    <= bus.csr_wdata;
        12'h342: m_cause  <= bus.csr_wdata;
        12'h343: m_tval   <= bus.csr_wdata;
        default: ;
      endcase
    end
  end

  function automatic logic [31:0] ref_trap_status(logic [31:0] ms);
    logic [31:0] r = ms;
    r[7] = ms[3];
    r[3] = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] ref_mret_status(logic [31:0] ms);
    logic [31:0] r = ms;
    r[3] = ms[7];
    r[7] = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] ref_cause(logic [1:0] k);
    return (k == K_EBREAK) ? 32'd3 : (k == K_ILLEGAL) ? 32'd2 : 32'd11;
  endfunction

  task automatic core_write(input logic [11:0] a, input logic [31:0] d);
    bus.core_csr_addr = a;
    bus.core_csr_wdata = d;
    bus.core_csr_wen = 1'b1;
    @(posedge clk); #1;
    bus.core_csr_wen = 1'b0;
  endtask

  task automatic run_trap(input logic [1:0] kind, input logic [31:0] pc, input logic [31:0] tval,
                          output logic acc_ready, output logic acc_gnt, output logic acc_wen,
                          output int rcyc, output logic [31:0] rpc, output int rcnt,
                          output int bcnt, output int wen_redir);
    bus.trap_valid = 1'b1;
    bus.trap_kind = kind;
    bus.trap_pc = pc;
    last_tval = tval;
`ifdef TRAP_MTVAL_EN
    bus.trap_tval = tval;
`endif
    @(negedge clk);
    acc_ready = bus.trap_ready;
    acc_gnt = bus.core_csr_gnt;
    acc_wen = bus.csr_wen;
    @(posedge clk); #1;
    bus.trap_valid = 1'b0;
    rcyc = -1; rpc = '0; rcnt = 0; bcnt = 0; wen_redir = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) bcnt++;
      if (bus.redirect_valid === 1'b1) begin
        rcnt++;
        if (rcyc < 0) begin rcyc = c; rpc = bus.redirect_pc; end
        if (bus.csr_wen !== 1'b0) wen_redir++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL reset_redirect: got %b want 0", bus.redirect_valid); end
    total++; if (bus.csr_wen !== 1'b0) begin bad++; $display("FAIL reset_wen: got %b want 0", bus.csr_wen); end
    total++; if (bus.trap_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.trap_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.core_csr_gnt !== 1'b1) begin bad++; $display("FAIL reset_gnt: got %b want 1", bus.core_csr_gnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_passthrough();
    logic [31:0] v = $urandom;
    bus.core_csr_addr = 12'h305;
    bus.core_csr_wdata = v;
    bus.core_csr_wen = 1'b1;
    @(negedge clk);
    total++; if (bus.csr_wen !== 1'b1) begin bad++; $display("FAIL pass_wen: got %b want 1", bus.csr_wen); end
    total++; if (bus.csr_addr !== 12'h305) begin bad++; $display("FAIL pass_addr: got %h want 305", bus.csr_addr); end
    @(posedge clk); #1;
    bus.core_csr_wen = 1'b0;
    @(negedge clk);
    total++; if (bus.core_csr_rdata !== v) begin bad++; $display("FAIL pass_rdata: got %h want %h", bus.core_csr_rdata, v); end
    @(posedge clk); #1;
  endtask

  task automatic test_ecall();
    logic ar, ag, aw; int rc, rn, bc, wr; logic [31:0] rp;
    core_write(12'h300, 32'h0000_1808);
    core_write(12'h305, 32'h8000_1000);
    core_write(12'h342, 32'h0);
    core_write(12'h343, 32'h1234);
    run_trap(K_ECALL, 32'h8000_0104, 32'h5555_5555, ar, ag, aw, rc, rp, rn, bc, wr);
    total++; if (ar !== 1'b1) begin bad++; $display("FAIL ecall_ready: got %b want 1", ar); end
    total++; if (rc != EXC_LAT) begin bad++; $display("FAIL ecall_redir_cycle: got %0d want %0d", rc, EXC_LAT); end
    total++; if (rp !== 32'h8000_1000) begin bad++; $display("FAIL ecall_redir_pc: got %h want 80001000", rp); end
    total++; if (rn != 1) begin bad++; $display("FAIL ecall_redir_count: got %0d want 1", rn); end
    total++; if (bc != EXC_LAT) begin bad++; $display("FAIL ecall_busy_cycles: got %0d want %0d", bc, EXC_LAT); end
    total++; if (wr != 0) begin bad++; $display("FAIL ecall_wen_in_redirect: got %0d want 0", wr); end
    total++; if (m_epc !== 32'h8000_0104) begin bad++; $display("FAIL ecall_mepc: got %h want 80000104", m_epc); end
    total++; if (m_cause !== 32'd11) begin bad++; $display("FAIL ecall_mcause: got %h want b", m_cause); end
    total++; if (m_status !== 32'h0000_1880) begin bad++; $display("FAIL ecall_mstatus: got %h want 1880", m_status); end
`ifdef TRAP_MTVAL_EN
    total++; if (m_tval !== 32'h0) begin bad++; $display("FAIL ecall_mtval: got %h want 0", m_tval); end
`else
    total++; if (m_tval !== 32'h1234) begin bad++; $display("FAIL ecall_mtval_untouched: got %h want 1234", m_tval); end
`endif
  endtask

  task automatic test_mret();
    logic ar, ag, aw; int rc, rn, bc, wr; logic [31:0] rp;
    run_trap(K_MRET, 32'h1234_5678, 32'h0, ar, ag, aw, rc, rp, rn, bc, wr);
    total++; if (rc != 2) begin bad++; $display("FAIL mret_redir_cycle: got %0d want 2", rc); end
    total++; if (rp !== 32'h8000_0104) begin bad++; $display("FAIL mret_redir_pc: got %h want 80000104", rp); end
    total++; if (bc != 2) begin bad++; $display("FAIL mret_busy_cycles: got %0d want 2", bc); end
    total++; if (m_status !== 32'h0000_1888) begin bad++; $display("FAIL mret_mstatus: got %h want 1888", m_status); end
    total++; if (m_cause !== 32'd11) begin bad++; $display("FAIL mret_mcause_kept: got %h want b", m_cause); end
  endtask

  task automatic test_illegal();
    logic ar, ag, aw; int rc, rn, bc, wr; logic [31:0] rp;
    core_write(12'h305, 32'h8000_1003);
    run_trap(K_ILLEGAL, 32'h8000_0202, 32'hdead_beef, ar, ag, aw, rc, rp, rn, bc, wr);
    total++; if (m_epc !== 32'h8000_0200) begin bad++; $display("FAIL ill_mepc_aligned: got %h want 80000200", m_epc); end
    total++; if (m_cause !== 32'd2) begin bad++; $display("FAIL ill_mcause: got %h want 2", m_cause); end
    total++; if (rp !== 32'h8000_1000) begin bad++; $display("FAIL ill_redir_pc: got %h want 80001000", rp); end
    total++; if (rc != EXC_LAT) begin bad++; $display("FAIL ill_redir_cycle: got %0d want %0d", rc, EXC_LAT); end
`ifdef TRAP_MTVAL_EN
    total++; if (m_tval !== 32'hdead_beef) begin bad++; $display("FAIL ill_mtval: got %h want deadbeef", m_tval); end
`endif
  endtask

  task automatic test_arbitration();
    logic ar, ag, aw; int rc, rn, bc, wr; logic [31:0] rp;
    core_write(12'h305, 32'h8000_1000);
    bus.core_csr_addr = 12'h305;
    bus.core_csr_wdata = 32'h8000_2000;
    bus.core_csr_wen = 1'b1;
    run_trap(K_EBREAK, 32'h8000_0010, 32'h0, ar, ag, aw, rc, rp, rn, bc, wr);
    total++; if (ag !== 1'b0) begin bad++; $display("FAIL arb_gnt_on_trap: got %b want 0", ag); end
    total++; if (aw !== 1'b0) begin bad++; $display("FAIL arb_wen_masked: got %b want 0", aw); end
    total++; if (rp !== 32'h8000_1000) begin bad++; $display("FAIL arb_redir_old_mtvec: got %h want 80001000", rp); end
    total++; if (m_cause !== 32'd3) begin bad++; $display("FAIL arb_mcause: got %h want 3", m_cause); end
    @(negedge clk);
    total++; if (bus.core_csr_gnt !== 1'b1) begin bad++; $display("FAIL arb_gnt_after: got %b want 1", bus.core_csr_gnt); end
    total++; if (m_tvec !== 32'h8000_2000) begin bad++; $display("FAIL arb_core_write: got %h want 80002000", m_tvec); end
    @(posedge clk); #1;
    bus.core_csr_wen = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic wen_rst; int bc = 0, rn = 0, wc = 0;
    core_write(12'h342, 32'h5);
    core_write(12'h341, 32'h0);
    bus.trap_valid = 1'b1;
    bus.trap_kind = K_ECALL;
    bus.trap_pc = 32'h8000_0400;
    @(posedge clk); #1;
    bus.trap_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    wen_rst = bus.csr_wen;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) bc++;
      if (bus.redirect_valid === 1'b1) rn++;
      if (bus.csr_wen === 1'b1) wc++;
      @(posedge clk); #1;
    end
    total++; if (wen_rst !== 1'b0) begin bad++; $display("FAIL rstmid_wen: got %b want 0", wen_rst); end
    total++; if (bc != 0) begin bad++; $display("FAIL rstmid_busy: got %0d want 0", bc); end
    total++; if (rn != 0) begin bad++; $display("FAIL rstmid_redirect: got %0d want 0", rn); end
    total++; if (wc != 0) begin bad++; $display("FAIL rstmid_writes: got %0d want 0", wc); end
    total++; if (m_cause !== 32'h5) begin bad++; $display("FAIL rstmid_mcause: got %h want 5", m_cause); end
    total++; if (m_epc !== 32'h8000_0400) begin bad++; $display("FAIL rstmid_mepc: got %h want 80000400", m_epc); end
  endtask

  task automatic test_back_to_back();
    int acc[$]; int rdy_redir = 0; int gap = -1;
    core_write(12'h305, 32'h8000_3000);
    bus.trap_valid = 1'b1;
    bus.trap_kind = K_EBREAK;
    bus.trap_pc = 32'h8000_0800;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.trap_ready === 1'b1) acc.push_back(c);
      if (bus.redirect_valid === 1'b1 && bus.trap_ready !== 1'b0) rdy_redir++;
      @(posedge clk); #1;
    end
    bus.trap_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    if (acc.size() >= 2) gap = acc[1] - acc[0];
    total++; if (gap != EXC_LAT + 1) begin bad++; $display("FAIL b2b_accept_gap: got %0d want %0d", gap, EXC_LAT + 1); end
    total++; if (rdy_redir != 0) begin bad++; $display("FAIL b2b_ready_in_redirect: got %0d want 0", rdy_redir); end
  endtask

  task automatic test_random();
    logic ar, ag, aw; int rc, rn, bc, wr; logic [31:0] rp;
    logic [1:0] k; logic [31:0] ms, tv, ep, pc, tval, cs, mt, exp_pc, exp_st, exp_ep, exp_cs, exp_tv;
    int exp_lat;
    for (int i = 0; i < 24; i++) begin
      ms = $urandom; tv = $urandom; ep = $urandom; pc = $urandom; tval = $urandom;
      k = 2'($urandom_range(0, 3));
      core_write(12'h300, ms);
      core_write(12'h305, tv);
      core_write(12'h341, ep);
      cs = m_cause;
      mt = m_tval;
      if (k == K_MRET) begin
        exp_lat = 2; exp_pc = ep & ~32'd3; exp_st = ref_mret_status(ms);
        exp_ep = ep; exp_cs = cs; exp_tv = mt;
      end else begin
        exp_lat = EXC_LAT; exp_pc = tv & ~32'd3; exp_st = ref_trap_status(ms);
        exp_ep = pc & ~32'd3; exp_cs = ref_cause(k);
`ifdef TRAP_MTVAL_EN
        exp_tv = (k == K_ILLEGAL) ? tval : 32'd0;
`else
        exp_tv = mt;
`endif
      end
      run_trap(k, pc, tval, ar, ag, aw, rc, rp, rn, bc, wr);
      total++; if (rc != exp_lat) begin bad++; $display("FAIL rnd%0d_redir_cycle: kind %0d got %0d want %0d", i, k, rc, exp_lat); end
      total++; if (rp !== exp_pc) begin bad++; $display("FAIL rnd%0d_redir_pc: kind %0d got %h want %h", i, k, rp, exp_pc); end
      total++; if (bc != exp_lat) begin bad++; $display("FAIL rnd%0d_busy: kind %0d got %0d want %0d", i, k, bc, exp_lat); end
      total++; if (rn != 1 || wr != 0) begin bad++; $display("FAIL rnd%0d_redir_pulse: count %0d wen %0d want 1 0", i, rn, wr); end
      total++; if (m_status !== exp_st) begin bad++; $display("FAIL rnd%0d_mstatus: kind %0d got %h want %h", i, k, m_status, exp_st); end
      total++; if (m_epc !== exp_ep) begin bad++; $display("FAIL rnd%0d_mepc: kind %0d got %h want %h", i, k, m_epc, exp_ep); end
      total++; if (m_cause !== exp_cs) begin bad++; $display("FAIL rnd%0d_mcause: kind %0d got %h want %h", i, k, m_cause, exp_cs); end
      total++; if (m_tval !== exp_tv) begin bad++; $display("FAIL rnd%0d_mtval: kind %0d got %h want %h", i, k, m_tval, exp_tv); end
    end
  endtask

  initial begin
    bus.trap_valid = 1'b0;
    bus.trap_kind = 2'b00;
    bus.trap_pc = '0;
`ifdef TRAP_MTVAL_EN
    bus.trap_tval = '0;
`endif
    bus.core_csr_addr = '0;
    bus.core_csr_wdata = '0;
    bus.core_csr_wen = 1'b0;
    test_reset();
    test_passthrough();
    test_ecall();
    test_mret();
    test_illegal();
    test_arbitration();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
